// File: rtl/store_buffer_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : store_buffer_ctrl                                            |
// | Description : In-order store buffer between the LSU and the data-memory    |
// |               write port. Checks store alignment, lane-aligns data, builds |
// |               byte masks, drains entries one at a time with a req/ack      |
// |               handshake, and reports store-to-load hazards and drain state.|
// | Options     : STORE_COALESCE_EN - merge a store into the tail entry when   |
// |               both fall in the same doubleword.                            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module store_buffer_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        st_req_valid_i,
  output logic        st_req_ready_o,
  input  logic [63:0] st_addr_i,
  input  logic [1:0]  st_size_i,
  input  logic [63:0] st_data_i,
  output logic        st_misaligned_o,
  input  logic [63:0] ld_addr_i,
  input  logic [1:0]  ld_size_i,
  output logic        ld_hazard_o,
  input  logic        fence_i,
  output logic        drained_o,
  output logic        mem_req_valid_o,
  input  logic        mem_req_ready_i,
  output logic [63:0] mem_addr_o,
  output logic [63:0] mem_wdata_o,
  output logic [7:0]  mem_mask_o,
  input  logic        mem_ack_i
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // mem_access_size_t encoding
  localparam logic [1:0] SZ_BYTE   = 2'd0;
  localparam logic [1:0] SZ_HALF   = 2'd1;
  localparam logic [1:0] SZ_WORD   = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ      = 2'd1,
    ST_WAIT_ACK = 2'd2
  } state_t;

  // Natural alignment: the access must not cross its own size boundary.
  function automatic logic is_aligned(input logic [2:0] lo, input logic [1:0] size);
    case (size)
      SZ_BYTE: return 1'b1;
      SZ_HALF: return ~lo[0];
      SZ_WORD: return (lo[1:0] == 2'b00);
      default: return (lo == 3'b000);
    endcase
  endfunction

  // Byte-enable mask of an aligned access within its doubleword.
  function automatic logic [7:0] lane_mask(input logic [2:0] lo, input logic [1:0] size);
    case (size)
      SZ_BYTE: return 8'b0000_0001 << lo;
      SZ_HALF: return 8'b0000_0011 << {lo[2:1], 1'b0};
      SZ_WORD: return lo[2] ? 8'hF0 : 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  // LSB-justified store data moved into its byte lanes; other lanes are zero.
  function automatic logic [63:0] lane_data(input logic [2:0] lo, input logic [1:0] size,
                                            input logic [63:0] data);
    case (size)
      SZ_BYTE: return {56'd0, data[7:0]} << {lo, 3'b000};
      SZ_HALF: return {48'd0, data[15:0]} << {lo[2:1], 4'b0000};
      SZ_WORD: return lo[2] ? {data[31:0], 32'd0} : {32'd0, data[31:0]};
      default: return data;
    endcase
  endfunction

  // Widen a byte mask to a bit mask.
  function automatic logic [63:0] byte_expand(input logic [7:0] m);
    logic [63:0] r;
    r = '0;
    for (int b = 0; b < 8; b++) begin
      r[8*b +: 8] = {8{m[b]}};
    end
    return r;
  endfunction

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic               misaligned_q, misaligned_d;
  logic [60:0]        ent_addr_q [DEPTH];
  logic [60:0]        ent_addr_d [DEPTH];
  logic [63:0]        ent_data_q [DEPTH];
  logic [63:0]        ent_data_d [DEPTH];
  logic [7:0]         ent_mask_q [DEPTH];
  logic [7:0]         ent_mask_d [DEPTH];

  logic               st_aligned;
  logic [7:0]         st_mask;
  logic [63:0]        st_lane_data;
  logic               st_accept;
  logic               merge_hit;
  logic [PTR_W-1:0]   tail_ptr;
  logic               push;
  logic               pop;
  logic               req_active;
  logic [7:0]         ld_mask;
  logic [PTR_W-1:0]   hz_idx;
  logic               hazard;

  assign st_aligned   = is_aligned(st_addr_i[2:0], st_size_i);
  assign st_mask      = lane_mask(st_addr_i[2:0], st_size_i);
  assign st_lane_data = lane_data(st_addr_i[2:0], st_size_i, st_data_i);
  assign tail_ptr     = wr_ptr_q - PTR_W'(1);

`ifdef STORE_COALESCE_EN
  // Merge into the tail only if it is not the entry the drain FSM is working on.
  assign merge_hit = (count_q != '0) && st_aligned &&
                     (ent_addr_q[tail_ptr] == st_addr_i[63:3]) &&
                     !((tail_ptr == rd_ptr_q) && (state_q != ST_IDLE));
`else
  assign merge_hit = 1'b0;
`endif

  assign st_req_ready_o  = ((count_q < FULL_CNT) | merge_hit) & ~fence_i;
  assign st_accept       = st_req_valid_i & st_req_ready_o;
  assign st_misaligned_o = misaligned_q;
  assign drained_o       = (count_q == '0) && (state_q == ST_IDLE);

  assign mem_req_valid_o = req_active;
  assign mem_addr_o      = req_active ? {ent_addr_q[rd_ptr_q], 3'b000} : 64'd0;
  assign mem_wdata_o     = req_active ? ent_data_q[rd_ptr_q] : 64'd0;
  assign mem_mask_o      = req_active ? ent_mask_q[rd_ptr_q] : 8'd0;
  assign ld_hazard_o     = hazard;

  // State, pointers, occupancy and entry storage; reset drops every entry.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      misaligned_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_addr_q[i] <= '0;
        ent_data_q[i] <= '0;
        ent_mask_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      misaligned_q <= misaligned_d;
      for (int i = 0; i < DEPTH; i++) begin
        ent_addr_q[i] <= ent_addr_d[i];
        ent_data_q[i] <= ent_data_d[i];
        ent_mask_q[i] <= ent_mask_d[i];
      end
    end
  end

  // Drain sequencer: present the head, wait for acceptance, then for the ack.
  always_comb begin
    state_d    = state_q;
    req_active = 1'b0;
    pop        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (count_q != '0) state_d = ST_REQ;
      end
      ST_REQ: begin
        req_active = 1'b1;
        if (mem_req_ready_i) state_d = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (mem_ack_i) begin
          pop     = 1'b1;
          state_d = (count_q > CNT_W'(1)) ? ST_REQ : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Store intake: flag misaligned stores, merge or allocate aligned ones.
  always_comb begin
    count_d      = count_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    misaligned_d = 1'b0;
    push         = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      ent_addr_d[i] = ent_addr_q[i];
      ent_data_d[i] = ent_data_q[i];
      ent_mask_d[i] = ent_mask_q[i];
    end
    if (st_accept) begin
      if (!st_aligned) begin
        misaligned_d = 1'b1;
      end else if (merge_hit) begin
        ent_data_d[tail_ptr] = (ent_data_q[tail_ptr] & ~byte_expand(st_mask)) | st_lane_data;
        ent_mask_d[tail_ptr] = ent_mask_q[tail_ptr] | st_mask;
      end else begin
        ent_addr_d[wr_ptr_q] = st_addr_i[63:3];
        ent_data_d[wr_ptr_q] = st_lane_data;
        ent_mask_d[wr_ptr_q] = st_mask;
        wr_ptr_d             = wr_ptr_q + PTR_W'(1);
        push                 = 1'b1;
      end
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Load hazard: any live entry (including the one in flight) sharing a byte.
  always_comb begin
    ld_mask = lane_mask(ld_addr_i[2:0], ld_size_i);
    hazard  = 1'b0;
    hz_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hz_idx = rd_ptr_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && (ent_addr_q[hz_idx] == ld_addr_i[63:3]) &&
          ((ent_mask_q[hz_idx] & ld_mask) != 8'd0)) begin
        hazard = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_store_buffer_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_store_buffer_ctrl                                         |
// | Description : Self-checking bench for store_buffer_ctrl: vector table,     |
// |               directed multi-cycle sequences, random traffic vs. a queue   |
// |               model. Honours STORE_COALESCE_EN like the design.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_store_buffer_ctrl;

  localparam int DEPTH = 4;
  localparam logic [1:0] SB = 2'd0, SH = 2'd1, SW = 2'd2, SD = 2'd3;

  logic        clk = 1'b0;
  logic        resetn;
  logic        st_req_valid_i, st_req_ready_o;
  logic [63:0] st_addr_i, st_data_i;
  logic [1:0]  st_size_i;
  logic        st_misaligned_o;
  logic [63:0] ld_addr_i;
  logic [1:0]  ld_size_i;
  logic        ld_hazard_o, fence_i, drained_o;
  logic        mem_req_valid_o, mem_req_ready_i, mem_ack_i;
  logic [63:0] mem_addr_o, mem_wdata_o;
  logic [7:0]  mem_mask_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  store_buffer_ctrl #(.DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn),
    .st_req_valid_i(st_req_valid_i), .st_req_ready_o(st_req_ready_o),
    .st_addr_i(st_addr_i), .st_size_i(st_size_i), .st_data_i(st_data_i),
    .st_misaligned_o(st_misaligned_o),
    .ld_addr_i(ld_addr_i), .ld_size_i(ld_size_i), .ld_hazard_o(ld_hazard_o),
    .fence_i(fence_i), .drained_o(drained_o),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_mask_o(mem_mask_o),
    .mem_ack_i(mem_ack_i)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model helpers (byte arithmetic) ----------------
  function automatic logic m_aligned(input logic [2:0] lo, input logic [1:0] sz);
    int nb;
    nb = 1 << sz;
    return (int'(lo) % nb) == 0;
  endfunction

  function automatic logic [7:0] m_mask(input logic [2:0] lo, input logic [1:0] sz);
    int nb;
    nb = 1 << sz;
    return 8'(((1 << nb) - 1) << int'(lo));
  endfunction

  function automatic logic [63:0] m_data(input logic [2:0] lo, input logic [1:0] sz,
                                         input logic [63:0] raw);
    int nb;
    logic [63:0] keep;
    nb   = 1 << sz;
    keep = (nb == 8) ? ~64'd0 : ((64'd1 << (nb * 8)) - 64'd1);
    return (raw & keep) << (int'(lo) * 8);
  endfunction

  function automatic logic [63:0] m_bytes(input logic [7:0] m);
    logic [63:0] r;
    r = '0;
    for (int b = 0; b < 8; b++) if (m[b]) r |= 64'hFF << (8 * b);
    return r;
  endfunction

  typedef struct {
    logic [60:0] a;
    logic [63:0] d;
    logic [7:0]  m;
  } ent_t;

  ent_t q[$];
  int   ph;      // 0: idle, 1: request shown, 2: waiting for ack
  logic m_mis;

  // ------------------------------ vector table ------------------------------
  typedef struct {
    logic [1:0]  size;
    logic [63:0] addr;
    logic [63:0] data;
    logic        mis;
    logic [63:0] e_addr;
    logic [63:0] e_data;
    logic [7:0]  e_mask;
  } vec_t;

  vec_t vecs [9];

  task automatic idle_inputs();
    st_req_valid_i = 1'b0; st_addr_i = '0; st_size_i = SB; st_data_i = '0;
    ld_addr_i = '0; ld_size_i = SB; fence_i = 1'b0;
    mem_req_ready_i = 1'b0; mem_ack_i = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  // Present one store for one edge; returns at the following falling edge.
  task automatic push(input logic [1:0] sz, input logic [63:0] a, input logic [63:0] d);
    st_req_valid_i = 1'b1; st_size_i = sz; st_addr_i = a; st_data_i = d;
    @(negedge clk);
    st_req_valid_i = 1'b0;
  endtask

  task automatic run_random(input int ncyc);
    logic [63:0] bases [4];
    int sz, nb, mh, ldlo;
    logic exp_ready, acc, pop, hz;
    int nph;
    bases[0] = 64'h1000; bases[1] = 64'h1008; bases[2] = 64'h2000;
    bases[3] = 64'hFFFF_FFFF_FFFF_FFF8;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      st_req_valid_i  = ($urandom_range(0, 9) < 6);
      st_size_i       = 2'($urandom_range(0, 3));
      st_addr_i       = bases[$urandom_range(0, 3)] | 64'($urandom_range(0, 7));
      st_data_i       = {$urandom, $urandom};
      ld_size_i       = 2'($urandom_range(0, 3));
      nb              = 1 << ld_size_i;
      ldlo            = $urandom_range(0, 7) & ~(nb - 1);
      ld_addr_i       = bases[$urandom_range(0, 3)] | 64'(ldlo);
      fence_i         = ($urandom_range(0, 9) == 0);
      mem_req_ready_i = $urandom_range(0, 1);
      mem_ack_i       = $urandom_range(0, 1);
      #1;
      sz = q.size();
      mh = 0;
`ifdef STORE_COALESCE_EN
      if (sz > 0 && m_aligned(st_addr_i[2:0], st_size_i) && q[sz-1].a == st_addr_i[63:3] &&
          !(sz == 1 && ph != 0)) mh = 1;
`endif
      exp_ready = ((sz < DEPTH) || (mh == 1)) && !fence_i;
      hz = 1'b0;
      for (int i = 0; i < sz; i++)
        if (q[i].a == ld_addr_i[63:3] && (q[i].m & m_mask(ld_addr_i[2:0], ld_size_i)) != 0)
          hz = 1'b1;
      chk("rnd_ready", st_req_ready_o, exp_ready);
      chk("rnd_req_valid", mem_req_valid_o, ph == 1);
      chk("rnd_drained", drained_o, sz == 0 && ph == 0);
      chk("rnd_misaligned", st_misaligned_o, m_mis);
      chk("rnd_hazard", ld_hazard_o, hz);
      if (ph == 1 && sz > 0) begin
        chk("rnd_mem_addr", mem_addr_o, {q[0].a, 3'b000});
        chk("rnd_mem_wdata", mem_wdata_o, q[0].d);
        chk("rnd_mem_mask", mem_mask_o, q[0].m);
      end
      // advance the model across the coming edge
      acc = st_req_valid_i && exp_ready;
      pop = (ph == 2) && mem_ack_i;
      case (ph)
        0:       nph = (sz > 0) ? 1 : 0;
        1:       nph = mem_req_ready_i ? 2 : 1;
        default: nph = mem_ack_i ? ((sz > 1) ? 1 : 0) : 2;
      endcase
      m_mis = acc && !m_aligned(st_addr_i[2:0], st_size_i);
      if (acc && !m_mis) begin
        if (mh == 1) begin
          ent_t e;
          e   = q[sz-1];
          e.d = (e.d & ~m_bytes(m_mask(st_addr_i[2:0], st_size_i))) |
                m_data(st_addr_i[2:0], st_size_i, st_data_i);
          e.m = e.m | m_mask(st_addr_i[2:0], st_size_i);
          q[sz-1] = e;
        end else begin
          ent_t e;
          e.a = st_addr_i[63:3];
          e.d = m_data(st_addr_i[2:0], st_size_i, st_data_i);
          e.m = m_mask(st_addr_i[2:0], st_size_i);
          q.push_back(e);
        end
      end
      if (pop) void'(q.pop_front());
      ph = nph;
    end
  endtask

  initial begin
    int nw;
    logic [63:0] wa [4];
    logic [63:0] wd [4];
    logic [7:0]  wm [4];

    vecs[0] = '{SB, 64'h1003, 64'hAB, 1'b0, 64'h1000, 64'h0000_0000_AB00_0000, 8'h08};
    vecs[1] = '{SW, 64'h2006, 64'h1234_5678, 1'b1, 64'h0, 64'h0, 8'h00};
    vecs[2] = '{SH, 64'h1006, 64'h1234_BEEF, 1'b0, 64'h1000, 64'hBEEF_0000_0000_0000, 8'hC0};
    vecs[3] = '{SW, 64'h2004, 64'hFFFF_FFFF_CAFE_BABE, 1'b0, 64'h2000, 64'hCAFE_BABE_0000_0000, 8'hF0};
    vecs[4] = '{SW, 64'h2000, 64'h1111_2222_3333_4444, 1'b0, 64'h2000, 64'h0000_0000_3333_4444, 8'h0F};
    vecs[5] = '{SD, 64'h3008, 64'h0123_4567_89AB_CDEF, 1'b0, 64'h3008, 64'h0123_4567_89AB_CDEF, 8'hFF};
    vecs[6] = '{SD, 64'h300C, 64'h55, 1'b1, 64'h0, 64'h0, 8'h00};
    vecs[7] = '{SH, 64'h4001, 64'h66, 1'b1, 64'h0, 64'h0, 8'h00};
    vecs[8] = '{SB, 64'h5000, 64'hFFFF_FFFF_FFFF_FF77, 1'b0, 64'h5000, 64'h77, 8'h01};

    idle_inputs();
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", st_req_ready_o, 1'b1);
    chk("rst_drained", drained_o, 1'b1);
    chk("rst_req_valid", mem_req_valid_o, 1'b0);
    chk("rst_misaligned", st_misaligned_o, 1'b0);
    chk("rst_hazard", ld_hazard_o, 1'b0);
    chk("rst_mem_addr", mem_addr_o, 64'd0);
    chk("rst_mem_mask", mem_mask_o, 8'd0);
    resetn = 1'b1;
    @(negedge clk);

    // Single stores into an empty buffer with an always-ready memory.
    mem_req_ready_i = 1'b1; mem_ack_i = 1'b1;
    for (int v = 0; v < 9; v++) begin
      chk("vec_ready", st_req_ready_o, 1'b1);
      push(vecs[v].size, vecs[v].addr, vecs[v].data);
      chk("vec_misaligned", st_misaligned_o, vecs[v].mis);
      chk("vec_req_early", mem_req_valid_o, 1'b0);
      @(negedge clk);
      chk("vec_misaligned_gone", st_misaligned_o, 1'b0);
      chk("vec_req_valid", mem_req_valid_o, !vecs[v].mis);
      if (!vecs[v].mis) begin
        chk("vec_mem_addr", mem_addr_o, vecs[v].e_addr);
        chk("vec_mem_wdata", mem_wdata_o, vecs[v].e_data);
        chk("vec_mem_mask", mem_mask_o, vecs[v].e_mask);
      end
      repeat (3) @(negedge clk);
      chk("vec_drained", drained_o, 1'b1);
    end

    // Fill to DEPTH with memory stalled, then drain in order.
    mem_req_ready_i = 1'b0; mem_ack_i = 1'b0;
    for (int i = 0; i < 4; i++) push(SD, 64'h100 + 64'(8 * i), 64'(i + 1));
    chk("full_ready", st_req_ready_o, 1'b0);
    st_req_valid_i = 1'b1; st_size_i = SD; st_addr_i = 64'h200; st_data_i = 64'h99;
    @(negedge clk);
    chk("full_ready_hold", st_req_ready_o, 1'b0);
    st_req_valid_i = 1'b0;
    mem_req_ready_i = 1'b1; mem_ack_i = 1'b1;
    nw = 0;
    for (int c = 0; c < 40; c++) begin
      if (mem_req_valid_o) begin
        if (nw < 4) chk("fill_order_addr", mem_addr_o, 64'h100 + 64'(8 * nw));
        if (nw == 0) chk("fill_ready_before_ack", st_req_ready_o, 1'b0);
        if (nw == 1) chk("fill_ready_after_ack", st_req_ready_o, 1'b1);
        nw++;
      end
      @(negedge clk);
    end
    chk("fill_write_count", 64'(nw), 64'd4);
    chk("fill_drained", drained_o, 1'b1);

    // Store-to-load hazard.
    mem_req_ready_i = 1'b0; mem_ack_i = 1'b0;
    push(SW, 64'h3004, 64'hDEAD_BEEF);
    ld_addr_i = 64'h3004; ld_size_i = SW; #1;
    chk("hz_lw_hit", ld_hazard_o, 1'b1);
    ld_addr_i = 64'h3003; ld_size_i = SB; #1;
    chk("hz_lb_miss", ld_hazard_o, 1'b0);
    ld_addr_i = 64'h3000; ld_size_i = SD; #1;
    chk("hz_ld_hit", ld_hazard_o, 1'b1);
    mem_req_ready_i = 1'b1; mem_ack_i = 1'b1;
    repeat (4) @(negedge clk);
    chk("hz_drained", drained_o, 1'b1);
    ld_addr_i = 64'h3004; ld_size_i = SW; #1;
    chk("hz_lw_after", ld_hazard_o, 1'b0);
    ld_addr_i = 64'h3003; ld_size_i = SB; #1;
    chk("hz_lb_after", ld_hazard_o, 1'b0);

    // Fence blocks stores; drained only after the last ack.
    mem_req_ready_i = 1'b0; mem_ack_i = 1'b0;
    push(SD, 64'h600, 64'h1);
    push(SD, 64'h608, 64'h2);
    fence_i = 1'b1; #1;
    chk("fence_ready", st_req_ready_o, 1'b0);
    st_req_valid_i = 1'b1; st_size_i = SD; st_addr_i = 64'h610;
    mem_req_ready_i = 1'b1; mem_ack_i = 1'b1;
    nw = 0;
    for (int c = 0; c < 30; c++) begin
      if (mem_req_valid_o) begin
        nw++;
        if (nw == 2) begin
          chk("fence_drained_req2", drained_o, 1'b0);
          @(negedge clk);
          chk("fence_drained_wait2", drained_o, 1'b0);
          @(negedge clk);
          chk("fence_drained_final", drained_o, 1'b1);
        end
      end
      @(negedge clk);
    end
    chk("fence_write_count", 64'(nw), 64'd2);
    st_req_valid_i = 1'b0; fence_i = 1'b0; #1;
    chk("fence_release_ready", st_req_ready_o, 1'b1);

    // Coalescing behind an unrelated stalled head.
    mem_req_ready_i = 1'b0; mem_ack_i = 1'b0;
    push(SD, 64'h5000, 64'hAAAA);
    @(negedge clk);
    push(SB, 64'h4000, 64'h11);
    push(SB, 64'h4001, 64'h22);
    mem_req_ready_i = 1'b1; mem_ack_i = 1'b1;
    nw = 0;
    for (int c = 0; c < 30; c++) begin
      if (mem_req_valid_o && nw < 4) begin
        wa[nw] = mem_addr_o; wd[nw] = mem_wdata_o; wm[nw] = mem_mask_o;
        nw++;
      end
      @(negedge clk);
    end
    chk("co_head_addr", wa[0], 64'h5000);
`ifdef STORE_COALESCE_EN
    chk("co_write_count", 64'(nw), 64'd2);
    chk("co_merged_addr", wa[1], 64'h4000);
    chk("co_merged_mask", wm[1], 8'h03);
    chk("co_merged_data", wd[1], 64'h2211);
`else
    chk("co_write_count", 64'(nw), 64'd3);
    chk("co_first_mask", wm[1], 8'h01);
    chk("co_first_data", wd[1], 64'h11);
    chk("co_second_mask", wm[2], 8'h02);
    chk("co_second_data", wd[2], 64'h2200);
`endif

    // Reset while a write is outstanding abandons it.
    mem_req_ready_i = 1'b0; mem_ack_i = 1'b0;
    push(SD, 64'h700, 64'h7);
    @(negedge clk);
    chk("rstmid_req_before", mem_req_valid_o, 1'b1);
    #2 resetn = 1'b0;
    #1;
    chk("rstmid_req", mem_req_valid_o, 1'b0);
    chk("rstmid_drained", drained_o, 1'b1);
    @(negedge clk);
    resetn = 1'b1;
    mem_req_ready_i = 1'b1; mem_ack_i = 1'b1;
    nw = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (mem_req_valid_o) nw++;
    end
    chk("rstmid_no_retry", 64'(nw), 64'd0);

    // Random traffic against the queue model.
    idle_inputs();
    do_reset();
    q.delete();
    ph = 0;
    m_mis = 1'b0;
    run_random(3000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
